// File: rtl/pc_sequencer.sv
// Program counter, retired-instruction counter and enter-button synchroniser/debouncer.
// Define PC_DEBOUNCE_EN to enable the debounce FSM; otherwise a bare rising-edge detector is used.
module pc_sequencer #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned RETIRE_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              cu_Jump,
    input  logic                    cu_Branch,
    input  logic                    cu_hlt,
    input  logic                    cu_reset,
    input  logic                    branch_taken,
    input  logic [ADDR_WIDTH-1:0]   imm_addr,
    input  logic [31:0]             reg_addr,
    input  logic                    enter_button,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic [ADDR_WIDTH-1:0]   pc_link,
    output logic                    enterFlag,
    output logic                    halted,
    output logic [RETIRE_WIDTH-1:0] retired
);

    localparam logic [1:0] JUMP_IMM = 2'b01;
    localparam logic [1:0] JUMP_REG = 2'b10;

    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
    logic                    halted_q, halted_d;

    // cu_reset and cu_hlt are tested first so lower-priority inputs never reach pc.
    always_comb begin
        pc_d = pc_q + ADDR_WIDTH'(1);
        if (cu_reset) begin
            pc_d = '0;
        end else if (cu_hlt) begin
            pc_d = pc_q;
        end else if (cu_Jump == JUMP_IMM) begin
            pc_d = imm_addr;
        end else if (cu_Jump == JUMP_REG) begin
            pc_d = reg_addr[ADDR_WIDTH-1:0];
        end else if (cu_Branch && branch_taken) begin
            pc_d = imm_addr;
        end
    end

    always_comb begin
        retired_d = retired_q;
        if (cu_reset) begin
            retired_d = '0;
        end else if (!cu_hlt) begin
            retired_d = retired_q + RETIRE_WIDTH'(1);
        end
    end

    assign halted_d = cu_hlt && !cu_reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign pc      = pc_q;
    assign pc_link = pc_q + ADDR_WIDTH'(1);
    assign halted  = halted_q;
    assign retired = retired_q;

    generate
        if (ADDR_WIDTH < 32) begin : g_reg_hi
            logic unused_reg_hi;
            assign unused_reg_hi = ^reg_addr[31:ADDR_WIDTH];
        end
    endgenerate

    // Two-flop synchroniser for the asynchronous push button.
    logic [1:0] sync_q;
    logic       synced;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], enter_button};
        end
    end

    assign synced = sync_q[1];

`ifdef PC_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_HELD         = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (synced) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!synced) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!synced) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (synced) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign enterFlag = (state_q != ST_PRESSED);
`else
    logic sync_prev_q;
    logic pulse_q;
    logic unused_debounce_cfg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_prev_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            sync_prev_q <= synced;
            pulse_q     <= synced && !sync_prev_q;
        end
    end

    assign enterFlag           = !pulse_q;
    assign unused_debounce_cfg = (DEBOUNCE_CYCLES > 0);
`endif

    // A press yields exactly one low cycle, and a held PC really holds.
    a_single_pulse: assert property (@(posedge clock) disable iff (reset)
        !enterFlag |=> enterFlag);
    a_hold_pc: assert property (@(posedge clock) disable iff (reset)
        (cu_hlt && !cu_reset) |=> (pc_q == $past(pc_q)));

endmodule
